// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer (SLL/SRL/SRA/SLB) with a start/ready/done handshake.
// Optional macro SHIFT_SEQ_FAST2_EN: shift two bits per cycle while at least two remain.
module shift_seq_ctrl #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [XLEN-1:0]    operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_SLB = 2'b11;

    logic [1:0]         state_reg;
    logic [XLEN-1:0]    acc_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    logic [1:0]         op_reg;
    logic [XLEN-1:0]    result_reg;

    logic [XLEN-1:0]    acc_next;
    logic [SHAMT_W-1:0] cnt_next;
    logic [SHAMT_W-1:0] eff_cnt;

    function automatic logic [XLEN-1:0] shift1(input logic [XLEN-1:0] v, input logic [1:0] o);
        case (o)
            OP_SRL:  return {1'b0, v[XLEN-1:1]};
            OP_SRA:  return {v[XLEN-1], v[XLEN-1:1]};
            default: return {v[XLEN-2:0], 1'b0};
        endcase
    endfunction

    always_comb begin
        acc_next = shift1(acc_reg, op_reg);
        cnt_next = cnt_reg - SHAMT_W'(1);
`ifdef SHIFT_SEQ_FAST2_EN
        if (cnt_reg >= SHAMT_W'(2)) begin
            acc_next = shift1(shift1(acc_reg, op_reg), op_reg);
            cnt_next = cnt_reg - SHAMT_W'(2);
        end
`endif
    end

    // SLB ignores shamt and always shifts exactly once.
    assign eff_cnt = (op == OP_SLB) ? SHAMT_W'(1) : shamt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            op_reg     <= OP_SLL;
            result_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        acc_reg <= operand;
                        op_reg  <= op;
                        cnt_reg <= eff_cnt;
                        if (eff_cnt == '0) begin
                            result_reg <= operand;
                            state_reg  <= S_DONE;
                        end else begin
                            state_reg  <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_next;
                    if (cnt_next == '0) begin
                        result_reg <= acc_next;
                        state_reg  <= S_DONE;
                    end
                end
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign ready  = (state_reg == S_IDLE);
    assign busy   = (state_reg == S_SHIFT) || (state_reg == S_DONE);
    assign done   = (state_reg == S_DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed, table-driven bench for shift_seq_ctrl plus hand-written handshake/reset sequences.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand = 32'h0;
    logic [4:0]  shamt = 5'd0;
    logic        ready, busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    shift_seq_ctrl #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand),
        .shamt(shamt), .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] operand;
        logic [4:0]  shamt;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [1:0] o, input logic [4:0] s);
        int n;
        n = (o == 2'b11) ? 1 : int'(s);
`ifdef SHIFT_SEQ_FAST2_EN
        return (n + 1) / 2;
`else
        return n;
`endif
    endfunction

    // Issue a request at the next rising edge (E0); returns with #1 after E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
        @(negedge clk);
        start = 1'b1; op = o; operand = v; shamt = s;
        @(posedge clk);
        #1;
        start = 1'b0; operand = ~v; shamt = ~s; op = ~o;
    endtask

    // Count edges after E0 until done is seen; -1 on timeout. Tracks result changes before done.
    task automatic wait_done(input logic [31:0] prev, output int lat, output int changed);
        lat = 0; changed = 0;
        while (!done && lat < 64) begin
            if (result !== prev) changed++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic run_vec(input int idx);
        int lat, changed;
        logic [31:0] prev;
        prev = result;
        issue(vecs[idx].op, vecs[idx].operand, vecs[idx].shamt);
        wait_done(prev, lat, changed);
        check($sformatf("v%0d_latency", idx), lat, exp_lat(vecs[idx].op, vecs[idx].shamt));
        check($sformatf("v%0d_result", idx), result, vecs[idx].exp);
        check($sformatf("v%0d_hold_midshift", idx), changed, 0);
        @(posedge clk); #1;
        check($sformatf("v%0d_done_pulse", idx), {30'd0, done, ready}, 32'd1);
    endtask

    initial begin
        int lat, changed, extra;

        vecs[0] = '{2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010};
        vecs[1] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[2] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[3] = '{2'b11, 32'h0000_0804, 5'd7,  32'h0000_1008};
        vecs[4] = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[5] = '{2'b10, 32'h8000_00F0, 5'd3,  32'hF000_001E};
        vecs[6] = '{2'b01, 32'hF000_0000, 5'd5,  32'h0780_0000};
        vecs[7] = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[8] = '{2'b10, 32'h4000_0000, 5'd30, 32'h0000_0001};
        vecs[9] = '{2'b00, 32'h1234_5678, 5'd1,  32'h2468_ACF0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {29'd0, ready, busy, done}, 32'b100);
        check("reset_result", result, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Start pulse during SHIFT is ignored
        issue(2'b00, 32'h0000_0001, 5'd4);
        @(negedge clk);
        start = 1'b1; op = 2'b01; operand = 32'hFFFF_0000; shamt = 5'd2;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        wait_done(result, lat, changed);
        check("busy_start_result", result, 32'h0000_0010);
        @(posedge clk); #1;
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) extra++;
            @(posedge clk); #1;
        end
        check("busy_start_no_extra_done", extra, 0);
        check("busy_start_ready", {31'd0, ready}, 32'd1);

        // Async reset mid-cycle during a shamt=10 operation
        issue(2'b00, 32'h0000_0003, 5'd10);
        @(posedge clk);      // E1
        #2 rst = 1'b1;
        #1;
        check("midreset_outputs", {29'd0, ready, busy, done}, 32'b100);
        check("midreset_result", result, 32'h0);
        @(posedge clk);      // E2 with rst high
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("midreset_no_done", extra, 0);
        check("midreset_result_after", result, 32'h0);

        // Fresh request after reset completes normally
        issue(2'b00, 32'h0000_0003, 5'd10);
        wait_done(32'h0, lat, changed);
        check("post_reset_latency", lat, exp_lat(2'b00, 5'd10));
        check("post_reset_result", result, 32'h0000_0C00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
